// File: rtl/ex_issue_arb.sv
// Round-robin issue arbiter: NREQ requesters share a single registered output entry feeding ex_wrapper.
// Optional performance counters are built only when EX_ISSUE_ARB_PERF_EN is defined.
module ex_issue_arb #(
  parameter int  NREQ          = 2,
  parameter int  ROB_DEPTHLOG2 = 4,
  parameter type dec_inst_t    = logic [31:0]
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  dec_inst_t                req_inst     [NREQ],
  input  logic [31:0]              req_A        [NREQ],
  input  logic [31:0]              req_B        [NREQ],
  input  logic [ROB_DEPTHLOG2-1:0] req_rob_slot [NREQ],
  input  logic                     flush,
  output dec_inst_t                ex_inst,
  output logic [31:0]              ex_A,
  output logic [31:0]              ex_B,
  output logic [ROB_DEPTHLOG2-1:0] ex_rob_slot,
  output logic                     ex_inst_valid,
  input  logic                     ex_ready,
  output logic [31:0]              perf_issue_cnt,
  output logic [31:0]              perf_block_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]         rr_ptr_reg;
  logic [PTR_W-1:0]         rr_ptr_next;
  logic [PTR_W-1:0]         winner;
  logic                     found;
  logic                     load_en;
  logic                     grant_en;
  logic                     ex_inst_valid_reg;
  dec_inst_t                ex_inst_reg;
  logic [31:0]              ex_A_reg;
  logic [31:0]              ex_B_reg;
  logic [ROB_DEPTHLOG2-1:0] ex_rob_slot_reg;

  // Reset also closes the load window so no grant is honoured in a reset cycle.
  assign load_en  = (~ex_inst_valid_reg | ex_ready) & ~flush & ~reset;
  assign grant_en = load_en & found;

  // Scan from rr_ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  assign rr_ptr_next = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_en && (winner == PTR_W'(gi));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_inst_valid_reg <= 1'b0;
      rr_ptr_reg        <= '0;
      ex_inst_reg       <= '0;
      ex_A_reg          <= '0;
      ex_B_reg          <= '0;
      ex_rob_slot_reg   <= '0;
    end else if (flush) begin
      ex_inst_valid_reg <= 1'b0;
    end else if (load_en) begin
      // With nothing to issue the entry empties; payload is left stale.
      ex_inst_valid_reg <= found;
      if (found) begin
        ex_inst_reg     <= req_inst[winner];
        ex_A_reg        <= req_A[winner];
        ex_B_reg        <= req_B[winner];
        ex_rob_slot_reg <= req_rob_slot[winner];
        rr_ptr_reg      <= rr_ptr_next;
      end
    end
  end

  assign ex_inst_valid = ex_inst_valid_reg;
  assign ex_inst       = ex_inst_reg;
  assign ex_A          = ex_A_reg;
  assign ex_B          = ex_B_reg;
  assign ex_rob_slot   = ex_rob_slot_reg;

`ifdef EX_ISSUE_ARB_PERF_EN
  logic [31:0] perf_issue_cnt_reg;
  logic [31:0] perf_block_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issue_cnt_reg <= '0;
      perf_block_cnt_reg <= '0;
    end else begin
      if (grant_en)
        perf_issue_cnt_reg <= perf_issue_cnt_reg + 32'd1;
      if ((|req_valid) && !(|req_ready))
        perf_block_cnt_reg <= perf_block_cnt_reg + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_issue_cnt_reg;
  assign perf_block_cnt = perf_block_cnt_reg;
`else
  assign perf_issue_cnt = 32'd0;
  assign perf_block_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_issue_arb.sv
// Directed bench for ex_issue_arb: a transaction-level model checked every cycle plus literal expectations.
module tb_ex_issue_arb;
  localparam int NREQ = 2;
  localparam int RW   = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       req_inst     [NREQ];
  logic [31:0]       req_A        [NREQ];
  logic [31:0]       req_B        [NREQ];
  logic [RW-1:0]     req_rob_slot [NREQ];
  logic              flush;
  logic [31:0]       ex_inst;
  logic [31:0]       ex_A;
  logic [31:0]       ex_B;
  logic [RW-1:0]     ex_rob_slot;
  logic              ex_inst_valid;
  logic              ex_ready;
  logic [31:0]       perf_issue_cnt;
  logic [31:0]       perf_block_cnt;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  ex_issue_arb #(.NREQ(NREQ), .ROB_DEPTHLOG2(RW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_inst(req_inst), .req_A(req_A), .req_B(req_B), .req_rob_slot(req_rob_slot),
    .flush(flush),
    .ex_inst(ex_inst), .ex_A(ex_A), .ex_B(ex_B), .ex_rob_slot(ex_rob_slot),
    .ex_inst_valid(ex_inst_valid), .ex_ready(ex_ready),
    .perf_issue_cnt(perf_issue_cnt), .perf_block_cnt(perf_block_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one held entry, a rotating priority start, two counters.
  bit          m_valid;
  int          m_rr;
  logic [31:0] m_inst, m_A, m_B;
  logic [RW-1:0] m_rob;
  int unsigned m_issue, m_block;

  function automatic int model_grant();
    if (reset || flush || (m_valid && !ex_ready)) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clock) begin
    int g;
    g = model_grant();
    if (reset) begin
      m_valid = 0; m_rr = 0; m_inst = 0; m_A = 0; m_B = 0; m_rob = 0;
      m_issue = 0; m_block = 0;
    end else begin
      if (req_valid != 0 && g < 0) m_block++;
      if (g >= 0) begin
        m_issue++;
        m_valid = 1;
        m_inst = req_inst[g]; m_A = req_A[g]; m_B = req_B[g]; m_rob = req_rob_slot[g];
        m_rr = (g + 1) % NREQ;
      end else if (flush || !m_valid || ex_ready) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      int g;
      logic [NREQ-1:0] exp_ready;
      g = model_grant();
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
      chk("m_ex_valid", 32'(ex_inst_valid), 32'(m_valid));
      chk("m_ex_A", ex_A, m_A);
      chk("m_ex_B", ex_B, m_B);
      chk("m_ex_inst", ex_inst, m_inst);
      chk("m_ex_rob", 32'(ex_rob_slot), 32'(m_rob));
`ifdef EX_ISSUE_ARB_PERF_EN
      chk("m_perf_issue", perf_issue_cnt, m_issue);
      chk("m_perf_block", perf_block_cnt, m_block);
`else
      chk("m_perf_issue", perf_issue_cnt, 32'd0);
      chk("m_perf_block", perf_block_cnt, 32'd0);
`endif
      $display("cyc t=%0t valid=%b ready=%b ex_v=%b ex_A=%h", $time, req_valid, req_ready, ex_inst_valid, ex_A);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < NREQ; i++) begin
      req_inst[i] = 32'hC0DE_0000 + 32'(i);
      req_A[i] = 32'hA0 + 32'(i);
      req_B[i] = 32'hB0 + 32'(i);
      req_rob_slot[i] = RW'(i + 2);
    end
    tick(); chk_en = 1'b1;
    tick(); #1;
    chk("rst_ex_valid", 32'(ex_inst_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ex_A", ex_A, 32'd0);

    // Alternating grants with both requesters valid and a ready consumer.
    reset = 1'b0; #1;
    chk("alt_g0", 32'(req_ready), 32'b01);
    tick(); #1;
    chk("alt_v1", 32'(ex_inst_valid), 32'd1);
    chk("alt_A0", ex_A, 32'hA0);
    chk("alt_g1", 32'(req_ready), 32'b10);
    tick(); #1;
    chk("alt_A1", ex_A, 32'hA1);
    chk("alt_g2", 32'(req_ready), 32'b01);
    tick(); #1;
    chk("alt_g3", 32'(req_ready), 32'b10);
    tick();
    chk("alt_A3", ex_A, 32'hA1);

    // Lone requester 1.
    req_valid = 2'b10; req_A[1] = 32'h1234; req_rob_slot[1] = 4'd5; #1;
    chk("solo_g1", 32'(req_ready), 32'b10);
    tick();
    chk("solo_A", ex_A, 32'h1234);
    chk("solo_rob", 32'(ex_rob_slot), 32'd5);
    chk("solo_v", 32'(ex_inst_valid), 32'd1);

    // Backpressure holds the entry; release grants requester 0 at once.
    req_valid = 2'b01; req_A[0] = 32'h55; ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_ready", 32'(req_ready), 32'b00);
      chk("hold_A", ex_A, 32'h1234);
      tick();
    end
    ex_ready = 1'b1; #1;
    chk("rel_g0", 32'(req_ready), 32'b01);
    tick();
    chk("rel_A", ex_A, 32'h55);

    // Flush beats everything and leaves the pointer at 1.
    req_valid = 2'b11; flush = 1'b1; #1;
    chk("fl_ready", 32'(req_ready), 32'b00);
    tick();
    chk("fl_v", 32'(ex_inst_valid), 32'd0);
    flush = 1'b0; #1;
    chk("fl_ptr", 32'(req_ready), 32'b10);
    tick();
    chk("fl_A", ex_A, 32'h1234);

    // Reset with a held entry drops it and rewinds the pointer.
    ex_ready = 1'b0; reset = 1'b1; #1;
    chk("rr_ready", 32'(req_ready), 32'b00);
    tick();
    chk("rr_v", 32'(ex_inst_valid), 32'd0);
    reset = 1'b0; ex_ready = 1'b1; #1;
    chk("rr_ptr", 32'(req_ready), 32'b01);
    tick();
    chk("rr_A", ex_A, 32'h55);

    // Counters: 5 transfers then 3 blocked cycles.
    reset = 1'b1; tick();
    reset = 1'b0; req_valid = 2'b01; ex_ready = 1'b1;
    repeat (5) tick();
    ex_ready = 1'b0;
    repeat (3) tick();
    req_valid = 2'b00; #1;
`ifdef EX_ISSUE_ARB_PERF_EN
    chk("perf_issue", perf_issue_cnt, 32'd5);
    chk("perf_block", perf_block_cnt, 32'd3);
`else
    chk("perf_issue", perf_issue_cnt, 32'd0);
    chk("perf_block", perf_block_cnt, 32'd0);
`endif
    ex_ready = 1'b1;
    tick(); tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_issue_arb.md
EX_ISSUE_ARB -- requirements
Module: ex_issue_arb

Interface
REQ-001 Parameter NREQ, 2, number of issue requesters sharing one ex_wrapper, legal range 2..8.
REQ-002 Parameter ROB_DEPTHLOG2, 4, ROB slot index width.
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester instruction valid.
REQ-006 req_ready  output  NREQ  per-requester grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-007 req_inst  input  NREQ x dec_inst_t  decoded instruction per requester.
REQ-008 req_A, req_B  input  NREQ x 32  operand values per requester.
REQ-009 req_rob_slot  input  NREQ x ROB_DEPTHLOG2  ROB slot per requester.
REQ-010 flush  input  1  discard the held entry and suppress all grants this cycle.
REQ-011 ex_inst, ex_A, ex_B, ex_rob_slot  output  dec_inst_t/32/32/ROB_DEPTHLOG2  registered payload to ex_wrapper.
REQ-012 ex_inst_valid  output  1  registered payload valid to ex_wrapper.
REQ-013 ex_ready  input  1  ex_wrapper ready; the held entry is consumed when ex_inst_valid & ex_ready.
REQ-014 perf_issue_cnt, perf_block_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-015 The block SHALL hold exactly one output entry (out register); load_en = ~ex_inst_valid | ex_ready, gated by ~flush.
REQ-016 Arbitration SHALL be round-robin: scan req_valid starting at rr_ptr, ascending and wrapping modulo NREQ; the first valid requester wins.
REQ-017 req_ready[i] SHALL be 1 only for the winner and only when load_en=1; at most one bit of req_ready is set in any cycle.
REQ-018 req_ready SHALL be combinational from req_valid, rr_ptr, ex_inst_valid, ex_ready and flush, and SHALL NOT depend on req payload.
REQ-019 On a transfer, the winner's inst/A/B/rob_slot SHALL load into the out register with ex_inst_valid=1 at the next edge (1-cycle latency).
REQ-020 On a transfer, rr_ptr SHALL become (winner+1) mod NREQ; otherwise rr_ptr is unchanged.
REQ-021 When load_en=1 and no request is valid, ex_inst_valid SHALL go to 0 at the next edge; payload may hold stale values.
REQ-022 When ex_inst_valid=1 and ex_ready=0, all outputs SHALL hold stable and req_ready SHALL be all-zero.
REQ-023 Simultaneous consume and grant (ex_ready=1 with a valid request) SHALL replace the entry back-to-back, sustaining 1 issue/cycle.
REQ-024 flush=1 SHALL clear ex_inst_valid at the next edge, force req_ready=0, leave rr_ptr unchanged, and take priority over ex_ready and all requests.
REQ-025 Requesters SHALL hold req_valid and payload stable until granted; the block does not check this.
REQ-026 Starvation bound: a continuously valid requester SHALL be granted within NREQ transfers.

Reset
REQ-027 While reset=1 at an edge: ex_inst_valid=0, rr_ptr=0, ex_A=ex_B=0, ex_rob_slot=0, counters=0; req_ready=0 while reset is asserted.
REQ-028 Reset asserted mid-transfer SHALL drop the held entry; no grant is honoured in a reset cycle.

Configuration
REQ-029 Macro EX_ISSUE_ARB_PERF_EN: when defined, perf_issue_cnt SHALL increment on every transfer and perf_block_cnt SHALL increment each cycle with any req_valid=1 and req_ready all-zero; both wrap modulo 2^32 and are cleared by reset.
REQ-030 When EX_ISSUE_ARB_PERF_EN is undefined, both counters SHALL be constant 0 and no counter flops are synthesised.

Verification
REQ-031 Reset, then NREQ=2 with both requesters valid and ex_ready=1 held for 4 cycles -> grants alternate 0,1,0,1; ex_inst_valid=1 from cycle 2 onward.
REQ-032 Only req 1 valid with A=0x1234, rob_slot=5, ex_ready=1 -> next cycle ex_A=0x1234, ex_rob_slot=5, ex_inst_valid=1, rr_ptr=0.
REQ-033 Entry held with ex_ready=0 for 3 cycles while req 0 is valid -> outputs stable and req_ready=00; on ex_ready=1, req 0 is granted in the same cycle and its payload appears next cycle.
REQ-034 flush=1 with held entry and both requests valid -> req_ready=00, ex_inst_valid=0 next cycle, rr_ptr unchanged.
REQ-035 Reset asserted while ex_inst_valid=1 -> ex_inst_valid=0 and rr_ptr=0 next edge; the entry is never consumed.
REQ-036 With EX_ISSUE_ARB_PERF_EN defined: 5 transfers plus 3 blocked cycles -> perf_issue_cnt=5, perf_block_cnt=3; with the macro undefined, both counters read 0.
